uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive end of the team's UART link: recovers 8-bit bytes from an asynchronous, idle-high serial line (8 data bits, LSB first, 1 stop bit, optional even parity). It sits between the board RX pin and the byte-level consumer logic and is the counterpart of the transmitter in the same codebase. Each accepted byte is presented as a one-cycle valid pulse, and framing faults are flagged.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 9600, line bit rate
- OVERSAMPLE, 16, sample ticks per bit period (even, ≥ 8)
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- rxd  input  1  raw serial line, idle high, asynchronous to clk
- data_out  output  8  last accepted byte, held until the next accepted byte
- data_valid  output  1  one-cycle pulse: data_out was updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch (always 0 without PARITY_EN)

## Operation
- rxd passes through a 2-flop synchronizer; both flops reset to 1.
- Tick generator: DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated and clamped to ≥ 1. A tick pulses once every DIV clocks. The tick counter is cleared on entry to START so that sampling is aligned to the start edge.
- Bit phase counter: 0..OVERSAMPLE-1, advanced on each tick. Mid-bit sample at phase OVERSAMPLE/2-1.
- FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP, WAIT_HIGH.
  - IDLE: a synchronized 1→0 transition moves to START.
  - START: at the mid sample, line still 0 → DATA. Line 1 → IDLE (glitch rejected, no flag).
  - DATA: 8 mid-bit samples shifted in LSB first, then → PARITY or STOP.
  - PARITY: one mid-bit sample, compared against even parity of the 8 bits, then → STOP.
  - STOP: at the mid sample:
    - Line 1 and parity OK: load data_out, pulse data_valid, → IDLE.
    - Line 1 and parity bad: pulse parity_err, data_out unchanged, → IDLE.
    - Line 0: pulse frame_err, data_out unchanged, → WAIT_HIGH.
  - WAIT_HIGH: stays until the synchronized line is 1, then → IDLE. No new start is detected until then.
- Only one of data_valid, frame_err or parity_err pulses per frame. If parity is bad and the stop bit is 0, frame_err wins.
- The receiver re-arms at the stop-bit middle, so a back-to-back frame whose start bit follows immediately is received.

## Timing
- Reset values: data_out = 8'h00, data_valid = 0, frame_err = 0, parity_err = 0, FSM = IDLE, shift register = 0, synchronizer = 1.
- Reset asserted mid-frame aborts the frame immediately with no flag. Reception resumes at the first falling edge after reset release.
- Start-edge detection lags rxd by 2 clocks (synchronizer) plus 1 clock (edge detect).
- Status pulses are registered and assert on the clock after the stop-bit mid sample. Latency from the rxd falling edge is about 9.5 bit periods (10.5 with parity) plus 4 clocks.
- Sampling tolerance: the line may drift ±(OVERSAMPLE/2-1) ticks over a frame without error.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state is compiled in and an even-parity bit is expected after bit 7.
  - parity_err is driven as described above.
- UART_RX_PARITY_EN undefined:
  - No parity bit is expected; DATA goes directly to STOP.
  - parity_err is tied to 0. The port remains in the interface.

## Structure
- Shared package uart_pkg:
  - FSM state encoding (3-bit localparams).
  - Data width constant (8).
  - The DIV computation function, so that tx and rx agree.
- One sub-module: uart_baud_tick (parameterized divider with synchronous clear and tick output), shared with the transmitter.

## Test plan
All directed tests use CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16, so DIV=1 and one bit lasts 16 clocks.
- Frame 0xA5, good stop bit → exactly one data_valid pulse with data_out=8'hA5; frame_err and parity_err stay 0.
- rxd low for 4 clocks, then high → no pulse on any output; FSM back in IDLE; a following frame 0x3C is received correctly.
- Frame 0x3C with stop bit driven 0 for 32 clocks → one frame_err pulse; data_out keeps its previous value; no new start is taken until rxd returns to 1.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two data_valid pulses, exactly 160 clocks apart, with data 0x00 then 0xFF.
- rst pulsed after 4 data bits of a frame → all outputs 0 immediately and no flag for the aborted frame; the next frame 0x5A yields data_valid with 8'h5A.
- UART_RX_PARITY_EN defined: frame 0x07 with parity bit 0 → parity_err pulse and no data_valid. The same byte with parity bit 1 → data_valid with data_out=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver/transmitter FSM encoding and
// the baud divisor function so both ends derive the same tick rate.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side view of the UART receiver: serial line in, byte and status pulses out.
interface uart_rx_if;
    import uart_pkg::*;

    logic              rxd;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              parity_err;

    modport master (output rxd, input data_out, data_valid, frame_err, parity_err);
    modport slave  (input rxd, output data_out, data_valid, frame_err, parity_err);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one tick every DIV clocks, restartable via clr so
// the caller can align the tick grid to an external event.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1; define UART_RX_PARITY_EN for 8E1 (even parity checked).
// Samples each bit at its middle and re-arms at the stop-bit middle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_W);
    localparam logic [PW-1:0] MID_PH   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic              sync1, sync2, line_q;
    logic [2:0]        state;
    logic [PW-1:0]     phase;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg, data_q;
    logic              valid_q, ferr_q;
    logic              tick, fall, mid, start_clr;
`ifdef UART_RX_PARITY_EN
    logic              par_bad, perr_q;
`endif

    assign fall      = line_q & ~sync2;
    assign start_clr = (state == ST_IDLE) && fall;
    assign mid       = tick && (phase == MID_PH);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_clr),
        .tick (tick)
    );

    // line_q is the edge-detect history behind the two synchronizer flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            {sync1, sync2, line_q} <= 3'b111;
        else
            {sync1, sync2, line_q} <= {bus.rxd, sync1, sync2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            if (tick)
                phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
            case (state)
                ST_IDLE:
                    if (fall) begin
                        state <= ST_START;
                        phase <= '0;
                    end
                ST_START:
                    if (mid) begin
                        state   <= sync2 ? ST_IDLE : ST_DATA;
                        bit_cnt <= '0;
                    end
                ST_DATA:
                    if (mid) begin
                        shreg   <= {sync2, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state <= ST_AFTER_DATA;
                    end
`ifdef UART_RX_PARITY_EN
                ST_PARITY:
                    if (mid) begin
                        par_bad <= sync2 ^ (^shreg);
                        state   <= ST_STOP;
                    end
`endif
                // framing beats parity when both are wrong
                ST_STOP:
                    if (mid) begin
                        if (!sync2) begin
                            ferr_q <= 1'b1;
                            state  <= ST_WAIT_HIGH;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad) begin
                            perr_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
`endif
                        else begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                ST_WAIT_HIGH:
                    if (sync2)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized frame bench for uart_rx at DIV=1 (16 clocks per bit);
// outcomes predicted from frame contents by a behavioural model.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int BIT_CLKS   = 16;
    localparam int FRAME_CLKS = BIT_CLKS * (10 + (PAR_EN ? 1 : 0));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nv = 0, nf = 0, np = 0;
    int vcyc[$];
    logic [7:0] vdat[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            nv <= nv + 1;
            vcyc.push_back(cyc);
            vdat.push_back(bus.data_out);
        end
        if (bus.frame_err)  nf <= nf + 1;
        if (bus.parity_err) np <= np + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic level, input int n);
        bus.rxd = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
        if (PAR_EN) hold(par, BIT_CLKS);
        if (stop_ok) hold(1'b1, BIT_CLKS);
        else begin
            hold(1'b0, 2 * BIT_CLKS);
            hold(1'b1, BIT_CLKS);
        end
    endtask

    // 0 = byte accepted, 1 = framing error, 2 = parity error
    function automatic int model(input logic [7:0] d, input bit stop_ok, input bit par);
        if (!stop_ok) return 1;
        if (PAR_EN && (par != ^d)) return 2;
        return 0;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input bit stop_ok, input bit par);
        int v0, f0, p0, kind;
        v0 = nv; f0 = nf; p0 = np;
        send_frame(d, stop_ok, par);
        kind = model(d, stop_ok, par);
        if (kind == 0) last_good = d;
        chk({tag, ".valid"},  32'(nv - v0), 32'(kind == 0));
        chk({tag, ".frame"},  32'(nf - f0), 32'(kind == 1));
        chk({tag, ".parity"}, 32'(np - p0), 32'(kind == 2));
        chk({tag, ".data"},   32'(bus.data_out), 32'(last_good));
    endtask

    initial begin
        int v0, f0, p0, q0;
        logic [7:0] d;
        bit stop_ok, par;

        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.data",   32'(bus.data_out), 32'h00);
        chk("rst.valid",  32'(bus.data_valid), 32'h0);
        chk("rst.frame",  32'(bus.frame_err), 32'h0);
        chk("rst.parity", 32'(bus.parity_err), 32'h0);
        rst = 1'b0;
        hold(1'b1, 20);

        run_frame("a5", 8'hA5, 1'b1, ^8'hA5);

        v0 = nv; f0 = nf; p0 = np;
        hold(1'b0, 4);
        hold(1'b1, 40);
        chk("glitch.valid",  32'(nv - v0), 32'h0);
        chk("glitch.frame",  32'(nf - f0), 32'h0);
        chk("glitch.parity", 32'(np - p0), 32'h0);
        run_frame("post_glitch_3c", 8'h3C, 1'b1, ^8'h3C);

        run_frame("good_81", 8'h81, 1'b1, ^8'h81);
        run_frame("badstop_3c", 8'h3C, 1'b0, ^8'h3C);
        hold(1'b1, 10);

        v0 = nv; q0 = vcyc.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        last_good = 8'hFF;
        chk("b2b.count", 32'(nv - v0), 32'd2);
        chk("b2b.gap",  (vcyc.size() >= q0 + 2) ? 32'(vcyc[q0+1] - vcyc[q0]) : 32'hFFFF_FFFF, 32'(FRAME_CLKS));
        chk("b2b.d0",   (vdat.size() >= q0 + 2) ? 32'(vdat[q0])   : 32'hFFFF_FFFF, 32'h00);
        chk("b2b.d1",   (vdat.size() >= q0 + 2) ? 32'(vdat[q0+1]) : 32'hFFFF_FFFF, 32'hFF);
        hold(1'b1, 10);

        v0 = nv; f0 = nf; p0 = np;
        d = 8'hC3;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
        rst = 1'b1;
        #1;
        chk("midrst.data",   32'(bus.data_out), 32'h00);
        chk("midrst.valid",  32'(bus.data_valid), 32'h0);
        chk("midrst.frame",  32'(bus.frame_err), 32'h0);
        chk("midrst.parity", 32'(bus.parity_err), 32'h0);
        last_good = 8'h00;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 40);
        chk("midrst.noflag", 32'((nv - v0) + (nf - f0) + (np - p0)), 32'h0);
        run_frame("after_rst_5a", 8'h5A, 1'b1, ^8'h5A);

        if (PAR_EN) begin
            run_frame("par_bad_07",  8'h07, 1'b1, 1'b0);
            run_frame("par_good_07", 8'h07, 1'b1, 1'b1);
            run_frame("par_and_stop", 8'h07, 1'b0, 1'b0);
        end

        for (int n = 0; n < 30; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            par     = (^d) ^ ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d", n), d, stop_ok, par);
            hold(1'b1, $urandom_range(0, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
